// File: rtl/fdiv_seq.sv
// Sequential floating-point divider r = a / b: restoring mantissa divider, flush-to-zero inputs.
// Define FDIV_RADIX4_EN to retire two quotient bits per CALC cycle (results unchanged, fewer cycles).
module fdiv_seq #(
  parameter int exp   = 8,
  parameter int frac  = 23,
  parameter int width = exp + frac + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             round_mode,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] r,
  output logic [4:0]       flags
);
  localparam int RW = frac + 3;
  localparam int EW = exp + 2;
  localparam int CW = $clog2(frac + 4);
`ifdef FDIV_RADIX4_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif
  localparam logic signed [EW-1:0] E_BIAS = EW'((1 << (exp - 1)) - 1);
  localparam logic signed [EW-1:0] E_OVF  = EW'((1 << exp) - 1);
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic [width-1:0] QNAN = {1'b0, {exp{1'b1}}, 1'b1, {(frac - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  state_t r_state, w_state_next;
  logic r_busy, r_done, w_busy_next, w_done_next;

  logic                 r_sign, r_round;
  logic signed [EW-1:0] r_e;
  logic [RW-1:0]        r_rem, r_q;
  logic [frac:0]        r_div;
  logic [CW-1:0]        r_cnt;
  logic [width-1:0]     r_res;
  logic [4:0]           r_flags;

  // Operand classification (subnormals count as zero)
  logic [exp-1:0]  w_exp_a, w_exp_b;
  logic [frac-1:0] w_frac_a, w_frac_b;
  logic w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b, w_sign_in;
  assign w_exp_a   = a[width-2:frac];
  assign w_exp_b   = b[width-2:frac];
  assign w_frac_a  = a[frac-1:0];
  assign w_frac_b  = b[frac-1:0];
  assign w_zero_a  = (w_exp_a == '0);
  assign w_zero_b  = (w_exp_b == '0);
  assign w_inf_a   = (&w_exp_a) & ~(|w_frac_a);
  assign w_inf_b   = (&w_exp_b) & ~(|w_frac_b);
  assign w_nan_a   = (&w_exp_a) & (|w_frac_a);
  assign w_nan_b   = (&w_exp_b) & (|w_frac_b);
  assign w_sign_in = a[width-1] ^ b[width-1];

  logic             w_spec;
  logic [width-1:0] w_spec_r;
  logic [4:0]       w_spec_flags;
  always_comb begin
    w_spec       = 1'b1;
    w_spec_r     = '0;
    w_spec_flags = '0;
    if (w_nan_a | w_nan_b) begin
      w_spec_r = QNAN;
    end else if ((w_zero_a & w_zero_b) | (w_inf_a & w_inf_b)) begin
      w_spec_r     = QNAN;
      w_spec_flags = 5'b10000;
    end else if (w_inf_a) begin
      w_spec_r = {w_sign_in, {exp{1'b1}}, {frac{1'b0}}};
    end else if (w_zero_b) begin
      w_spec_r     = {w_sign_in, {exp{1'b1}}, {frac{1'b0}}};
      w_spec_flags = 5'b01000;
    end else if (w_zero_a | w_inf_b) begin
      w_spec_r = {w_sign_in, {(width - 1){1'b0}}};
    end else begin
      w_spec = 1'b0;
    end
  end

  // Chained compare/subtract/shift stages; one or two per CALC cycle
  logic [RW-1:0]     w_div_ext;
  logic [RW-1:0]     w_rem_chain [0:STAGES];
  logic [STAGES-1:0] w_qbits;
  assign w_div_ext      = {2'b00, r_div};
  assign w_rem_chain[0] = r_rem;
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [RW-1:0] w_diff;
      assign w_qbits[gi]        = (w_rem_chain[gi] >= w_div_ext);
      assign w_diff             = w_qbits[gi] ? (w_rem_chain[gi] - w_div_ext) : w_rem_chain[gi];
      assign w_rem_chain[gi+1]  = w_diff << 1;
    end
  endgenerate

  // Normalisation, rounding and range check of the finished quotient
  logic                 w_q_msb, w_guard, w_sticky, w_inc, w_carry, w_inexact;
  logic [frac:0]        w_mant;
  logic [frac+1:0]      w_mant_rnd;
  logic [frac-1:0]      w_frac_fin;
  logic signed [EW-1:0] w_e0, w_e_fin;
  logic [width-1:0]     w_norm_r;
  logic [4:0]           w_norm_flags;
  assign w_q_msb    = r_q[RW-1];
  assign w_mant     = w_q_msb ? r_q[RW-1:2] : r_q[RW-2:1];
  assign w_guard    = w_q_msb ? r_q[1] : r_q[0];
  assign w_sticky   = (w_q_msb & r_q[0]) | (|r_rem);
  assign w_e0       = w_q_msb ? r_e : (r_e - E_ONE);
  assign w_inc      = r_round & w_guard & (w_sticky | w_mant[0]);
  assign w_mant_rnd = {1'b0, w_mant} + {{(frac + 1){1'b0}}, w_inc};
  assign w_carry    = w_mant_rnd[frac+1];
  assign w_e_fin    = w_carry ? (w_e0 + E_ONE) : w_e0;
  assign w_frac_fin = w_carry ? w_mant_rnd[frac:1] : w_mant_rnd[frac-1:0];
  assign w_inexact  = w_guard | w_sticky;

  always_comb begin
    w_norm_r     = {r_sign, w_e_fin[exp-1:0], w_frac_fin};
    w_norm_flags = {4'b0000, w_inexact};
    if (w_e_fin >= E_OVF) begin
      w_norm_flags = 5'b00101;
      w_norm_r     = r_round ? {r_sign, {exp{1'b1}}, {frac{1'b0}}}
                             : {r_sign, {(exp - 1){1'b1}}, 1'b0, {frac{1'b1}}};
    end else if (w_e_fin <= E_ZERO) begin
      w_norm_flags = 5'b00011;
      w_norm_r     = {r_sign, {(width - 1){1'b0}}};
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = w_spec ? DONE : CALC;
      CALC:    if (r_cnt <= CW'(STAGES)) w_state_next = NORM;
      NORM:    w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    w_busy_next = (w_state_next != IDLE);
    w_done_next = (w_state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  // Result registers load on entry to DONE so they are valid while done is high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign  <= 1'b0;
      r_round <= 1'b0;
      r_e     <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_sign  <= w_sign_in;
          r_round <= round_mode;
          r_e     <= $signed({2'b00, w_exp_a}) - $signed({2'b00, w_exp_b}) + E_BIAS;
          r_rem   <= {2'b01, w_frac_a};
          r_div   <= {1'b1, w_frac_b};
          r_q     <= '0;
          r_cnt   <= CW'(RW);
          if (w_spec) begin
            r_res   <= w_spec_r;
            r_flags <= w_spec_flags;
          end
        end
        CALC: begin
`ifdef FDIV_RADIX4_EN
          if (r_cnt >= CW'(2)) begin
            r_rem <= w_rem_chain[2];
            r_q   <= {r_q[RW-3:0], w_qbits[0], w_qbits[1]};
            r_cnt <= r_cnt - CW'(2);
          end else begin
            r_rem <= w_rem_chain[1];
            r_q   <= {r_q[RW-2:0], w_qbits[0]};
            r_cnt <= r_cnt - CW'(1);
          end
`else
          r_rem <= w_rem_chain[1];
          r_q   <= {r_q[RW-2:0], w_qbits[0]};
          r_cnt <= r_cnt - CW'(1);
`endif
        end
        NORM: begin
          r_res   <= w_norm_r;
          r_flags <= w_norm_flags;
        end
        default: ;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign r     = r_res;
  assign flags = r_flags;
endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: directed vectors, randomized ops against an arithmetic model,
// start-while-busy, reset abort and back-to-back handshake.
module tb_fdiv_seq;
`ifdef FDIV_RADIX4_EN
  localparam int NLAT = 15;
`else
  localparam int NLAT = 28;
`endif

  logic        clk = 1'b0;
  logic        rst, start, round_mode;
  logic [31:0] a, b, r;
  logic [4:0]  flags;
  logic        busy, done;
  int n_tests = 0;
  int n_fail  = 0;

  fdiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .round_mode(round_mode),
    .busy(busy), .done(done), .r(r), .flags(flags)
  );

  always #5 clk = ~clk;

  // Reference: exact integer quotient of the significands, then round and range-check
  function automatic void model(input logic [31:0] ia, input logic [31:0] ib, input logic rm,
                                output logic [31:0] mr, output logic [4:0] mf, output bit sp);
    logic s;
    int ea, eb, e;
    longint fa, fb, num, den, q, rem, mant;
    bit za, zb, infa, infb, naa, nab, g, st, inx;
    s  = ia[31] ^ ib[31];
    ea = int'(ia[30:23]);
    eb = int'(ib[30:23]);
    fa = longint'(ia[22:0]);
    fb = longint'(ib[22:0]);
    za = (ea == 0);  zb = (eb == 0);
    infa = (ea == 255) && (fa == 0);  infb = (eb == 255) && (fb == 0);
    naa  = (ea == 255) && (fa != 0);  nab  = (eb == 255) && (fb != 0);
    sp = 1'b1;
    mf = 5'h00;
    mr = 32'h0;
    if (naa || nab) mr = 32'h7FC00000;
    else if ((za && zb) || (infa && infb)) begin mr = 32'h7FC00000; mf = 5'h10; end
    else if (infa) mr = {s, 8'hFF, 23'h0};
    else if (zb) begin mr = {s, 8'hFF, 23'h0}; mf = 5'h08; end
    else if (za || infb) mr = {s, 31'h0};
    else begin
      sp  = 1'b0;
      num = (64'sd8388608 + fa) * 64'sd33554432;
      den = 64'sd8388608 + fb;
      q   = num / den;
      rem = num % den;
      e   = ea - eb + 127;
      if (q >= 64'sd33554432) begin
        mant = q / 4;  g = ((q / 2) % 2) != 0;  st = ((q % 2) != 0) || (rem != 0);
      end else begin
        e = e - 1;
        mant = q / 2;  g = (q % 2) != 0;  st = (rem != 0);
      end
      inx = g || st;
      if (rm && g && (st || ((mant % 2) != 0))) mant = mant + 1;
      if (mant == 64'sd16777216) begin mant = mant / 2; e = e + 1; end
      if (e >= 255) begin
        mf = 5'h05;
        mr = rm ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
      end else if (e <= 0) begin
        mf = 5'h03;
        mr = {s, 31'h0};
      end else begin
        mf = {4'b0000, inx};
        mr = {s, 8'(e), 23'(mant)};
      end
    end
  endfunction

  function automatic logic [31:0] rand_operand();
    int k;
    logic s;
    k = $urandom_range(0, 19);
    s = 1'($urandom_range(0, 1));
    case (k)
      0: return {s, 31'h0};
      1: return {s, 8'hFF, 23'h0};
      2: return {s, 8'hFF, 23'($urandom_range(1, 8388607))};
      3: return {s, 8'h00, 23'($urandom_range(1, 8388607))};
      4, 5, 6, 7, 8: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
      default: return {s, 8'($urandom_range(100, 154)), 23'($urandom)};
    endcase
  endfunction

  // Issue one op (call between edges); returns at the negedge where done was seen
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic irm,
                        output logic [31:0] or_, output logic [4:0] of, output int lat,
                        output bit busy_ok);
    a = ia; b = ib; round_mode = irm; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; busy_ok = 1'b1; or_ = '0; of = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = c; or_ = r; of = flags;
        break;
      end
    end
    $display("[TB] op a=%08h b=%08h rm=%0d -> r=%08h flags=%02h lat=%0d", ia, ib, irm, or_, of, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; round_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_r got=%08h exp=00000000", r); end
    n_tests++; if (flags !== 5'h0) begin n_fail++; $display("FAIL reset_flags got=%02h exp=00", flags); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] d_a [10] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000000,
                              32'hFF800001, 32'hBF800000, 32'h7F000000, 32'h7F000000, 32'h00800000};
    logic [31:0] d_b [10] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h00000000, 32'h00000000,
                              32'h3F800000, 32'h7F800000, 32'h3E800000, 32'h3E800000, 32'h40000000};
    logic        d_rm [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] d_r [10] = '{32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA, 32'h7F800000, 32'h7FC00000,
                              32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h7F7FFFFF, 32'h00000000};
    logic [4:0]  d_f [10] = '{5'h00, 5'h01, 5'h01, 5'h08, 5'h10, 5'h00, 5'h00, 5'h05, 5'h05, 5'h03};
    logic        d_sp [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] got_r;
    logic [4:0]  got_f;
    int lat, exp_lat;
    bit bok;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      run_op(d_a[i], d_b[i], d_rm[i], got_r, got_f, lat, bok);
      exp_lat = d_sp[i] ? 1 : NLAT;
      n_tests++; if (got_r !== d_r[i]) begin n_fail++; $display("FAIL dir%0d_r got=%08h exp=%08h", i, got_r, d_r[i]); end
      n_tests++; if (got_f !== d_f[i]) begin n_fail++; $display("FAIL dir%0d_flags got=%02h exp=%02h", i, got_f, d_f[i]); end
      n_tests++; if (lat != exp_lat) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, exp_lat); end
      n_tests++; if (!bok) begin n_fail++; $display("FAIL dir%0d_busy got=low exp=high in cycles 1..%0d", i, exp_lat); end
    end
  endtask

  task automatic test_random();
    logic [31:0] ia, ib, mr, got_r;
    logic [4:0]  mf, got_f;
    logic        rm;
    bit sp, bok;
    int lat, exp_lat;
    for (int i = 0; i < 60; i++) begin
      ia = rand_operand(); ib = rand_operand(); rm = 1'($urandom_range(0, 1));
      model(ia, ib, rm, mr, mf, sp);
      exp_lat = sp ? 1 : NLAT;
      @(negedge clk);
      run_op(ia, ib, rm, got_r, got_f, lat, bok);
      n_tests++; if (got_r !== mr) begin n_fail++; $display("FAIL rnd%0d_r a=%08h b=%08h got=%08h exp=%08h", i, ia, ib, got_r, mr); end
      n_tests++; if (got_f !== mf) begin n_fail++; $display("FAIL rnd%0d_flags a=%08h b=%08h got=%02h exp=%02h", i, ia, ib, got_f, mf); end
      n_tests++; if (lat != exp_lat) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, exp_lat); end
    end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    int extra = 0;
    logic [31:0] got_r = '0;
    logic [4:0]  got_f = '0;
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; round_mode = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 5) begin a = 32'h3F800000; b = 32'h40400000; round_mode = 1'b0; start = 1'b1; end
      if (c == 6) start = 1'b0;
      if (done === 1'b1) begin lat = c; got_r = r; got_f = flags; break; end
    end
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    $display("[TB] ignore_start r=%08h flags=%02h lat=%0d extra_done=%0d", got_r, got_f, lat, extra);
    n_tests++; if (got_r !== 32'h40400000) begin n_fail++; $display("FAIL ignore_r got=%08h exp=40400000", got_r); end
    n_tests++; if (got_f !== 5'h00) begin n_fail++; $display("FAIL ignore_flags got=%02h exp=00", got_f); end
    n_tests++; if (lat != NLAT) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, NLAT); end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL ignore_extra_done got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_abort();
    int early = 0;
    logic [31:0] got_r;
    logic [4:0]  got_f;
    int lat;
    bit bok;
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; round_mode = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) early++;
    end
    rst = 1'b1;
    @(negedge clk);
    $display("[TB] reset_abort busy=%b done=%b r=%08h flags=%02h", busy, done, r, flags);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done); end
    n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL abort_r got=%08h exp=00000000", r); end
    n_tests++; if (flags !== 5'h0) begin n_fail++; $display("FAIL abort_flags got=%02h exp=00", flags); end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) early++;
    end
    n_tests++; if (early != 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", early); end
    @(negedge clk);
    run_op(32'h3F800000, 32'h40400000, 1'b1, got_r, got_f, lat, bok);
    n_tests++; if (got_r !== 32'h3EAAAAAB) begin n_fail++; $display("FAIL after_reset_r got=%08h exp=3EAAAAAB", got_r); end
    n_tests++; if (got_f !== 5'h01) begin n_fail++; $display("FAIL after_reset_flags got=%02h exp=01", got_f); end
    n_tests++; if (lat != NLAT) begin n_fail++; $display("FAIL after_reset_latency got=%0d exp=%0d", lat, NLAT); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ia, ib, mr, got_r;
    logic [4:0]  mf, got_f;
    logic        rm;
    bit sp, bok;
    int lat;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ia = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
      ib = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
      rm = 1'($urandom_range(0, 1));
      model(ia, ib, rm, mr, mf, sp);
      run_op(ia, ib, rm, got_r, got_f, lat, bok);
      n_tests++; if (got_r !== mr) begin n_fail++; $display("FAIL b2b%0d_r got=%08h exp=%08h", i, got_r, mr); end
      n_tests++; if (got_f !== mf) begin n_fail++; $display("FAIL b2b%0d_flags got=%02h exp=%02h", i, got_f, mf); end
      n_tests++; if (lat != NLAT) begin n_fail++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", i, lat, NLAT); end
      @(negedge clk);
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_done_pulse got=%b exp=0", i, done); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_idle_busy got=%b exp=0", i, busy); end
      n_tests++; if (r !== mr) begin n_fail++; $display("FAIL b2b%0d_r_held got=%08h exp=%08h", i, r, mr); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
